store_scheduler: RTL and testbench
==================================

STORE_SCHEDULER -- requirements
Module: store_scheduler

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of stable cycles required to accept a press or release (minimum 2).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 50000000, the hold cycles between auto-repeat grants (minimum 2); it is used only under REQ-024.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_raw  input  1  raw, asynchronous, bouncing store button (btnC).
REQ-006 The block SHALL have port req  input  3  store requests; bit0 = D flip-flop, bit1 = JK flip-flop, bit2 = T flip-flop.
REQ-007 The block SHALL have port store  output  3  one-hot, single-cycle store pulse to the granted flip-flop.
REQ-008 The block SHALL have port grant_idx  output  2  index of the last granted requester; 3 = none since reset.
REQ-009 The block SHALL have port miss  output  1  single-cycle pulse when an accepted press finds req == 0.
REQ-010 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 btn_raw SHALL pass through a 2-flop synchronizer; every reference below to btn means the synchronized value.
REQ-012 The FSM SHALL have the states IDLE, PRESS_DB, ISSUE, HELD and RELEASE_DB.
REQ-013 IDLE -> PRESS_DB SHALL occur when btn=1; the debounce counter clears on entry.
REQ-014 PRESS_DB SHALL increment the counter each cycle btn=1, return to IDLE on any btn=0, and go to ISSUE when the counter reaches DEBOUNCE_CYCLES-1.
REQ-015 ISSUE SHALL last exactly one cycle and then go to HELD.
REQ-016 In ISSUE, the block SHALL grant the first set req bit searching upward (mod 3) from ptr, drive store[k]=1 for that cycle only, set grant_idx=k one cycle later, and set ptr=(k+1) mod 3.
REQ-017 In ISSUE with req==0, the block SHALL assert miss for that cycle, keep store=0, and leave ptr and grant_idx unchanged.
REQ-018 req SHALL be sampled only in the ISSUE cycle; req changes in other states SHALL have no effect.
REQ-019 HELD -> RELEASE_DB SHALL occur on btn=0, with the counter cleared.
REQ-020 RELEASE_DB SHALL return to HELD on any btn=1 and go to IDLE after DEBOUNCE_CYCLES consecutive btn=0 cycles.
REQ-021 store SHALL never have more than one bit set and SHALL never be high in two consecutive cycles.
REQ-022 Counters SHALL be sized to hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES) and SHALL saturate rather than wrap.

Reset
REQ-023 On rst_n=0, asynchronously and regardless of state, the block SHALL set state=IDLE, store=0, miss=0, busy=0, grant_idx=3, ptr=0, clear all counters and clear the synchronizer flops; a press in progress is discarded.

Configuration
REQ-024 With STORE_AUTO_REPEAT_EN defined, HELD SHALL count cycles with btn=1 and, on reaching REPEAT_CYCLES-1, go to ISSUE; the count restarts on each HELD entry.
REQ-025 Without STORE_AUTO_REPEAT_EN, the block SHALL issue exactly one ISSUE per accepted press, and the repeat counter SHALL not be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-026 The bench SHALL cover: req=3'b111, three clean presses -> store pulses 001, 010, 100 in order, each one cycle wide, with grant_idx 0, 1, 2.
REQ-027 The bench SHALL cover: btn_raw high for 3 cycles, then low (bounce) -> no store pulse, busy returns to 0.
REQ-028 The bench SHALL cover: req=3'b000 at the accepted press -> miss is one cycle, store=0, grant_idx is still 3.
REQ-029 The bench SHALL cover: req=3'b101 with ptr=1 -> grant goes to bit2, then on the next press to bit0.
REQ-030 The bench SHALL cover: rst_n dropped in HELD -> all outputs reach reset values with no clock edge, and the next press is granted to bit0.
REQ-031 The bench SHALL cover, with STORE_AUTO_REPEAT_EN defined: button held 30 cycles after acceptance -> 3 additional store pulses spaced 9 cycles apart; without the macro, exactly 1 pulse.

Source files
------------

// File: rtl/store_scheduler.sv
// -----------------------------------------------------------------------------
// store_scheduler
//
// Debounces the store push-button and, once per accepted press, hands a
// single-cycle store pulse to one of three flip-flop demos (D, JK, T) using a
// round-robin pointer. The button is synchronized, debounced on both press
// and release, and a press that finds no requester raises a one-cycle miss.
//
// Optional feature (macro STORE_AUTO_REPEAT_EN):
//   When defined, holding the button keeps issuing grants every
//   REPEAT_CYCLES held cycles. When undefined, exactly one grant per press
//   and the repeat counter does not exist.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press / release (>= 2)
//   REPEAT_CYCLES    held cycles between auto-repeat grants (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw bouncing button, asynchronous to clk
//   req[2:0]   in   store requests: bit0 D-FF, bit1 JK-FF, bit2 T-FF
//   store[2:0] out  one-hot single-cycle store pulse to the granted FF
//   grant_idx  out  last granted index, 3 = nothing granted since reset
//   miss       out  one-cycle pulse when an accepted press finds req == 0
//   busy       out  high whenever the FSM is outside IDLE
// -----------------------------------------------------------------------------
module store_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic [2:0] req,
  output logic [2:0] store,
  output logic [1:0] grant_idx,
  output logic       miss,
  output logic       busy
);

  // One counter width covers both debounce and repeat ranges.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
`ifdef STORE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    ISSUE      = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       sync_reg;
  logic             btn;
  logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
`ifdef STORE_AUTO_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
`endif
  logic [1:0]       ptr_reg;
  logic [1:0]       grant_idx_reg;

  logic             issue_cyc;
  logic [2:0]       rot;
  logic             pick_valid;
  logic [1:0]       pick_off;
  logic [1:0]       pick_idx;

  // Counters never wrap: the FSM bounds them, but a stuck value is safer
  // than a wrap if a parameter is ever set outside its intended range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous button
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
    end
  end

  assign btn = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate req so rot[0] is the requester at ptr, take the
  // lowest set bit of the rotated vector, then rotate the offset back.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ptr_reg)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    pick_valid = |req;
    if (rot[0])      pick_off = 2'd0;
    else if (rot[1]) pick_off = 2'd1;
    else             pick_off = 2'd2;
    pick_idx = add_mod3(ptr_reg, pick_off);
  end

  assign issue_cyc = (state_reg == ISSUE);

  // req only matters in the ISSUE cycle, so store/miss are gated by it.
  for (genvar gi = 0; gi < 3; gi++) begin : g_store
    assign store[gi] = issue_cyc && pick_valid && (pick_idx == 2'(gi));
  end

  assign miss      = issue_cyc && !pick_valid;
  assign busy      = (state_reg != IDLE);
  assign grant_idx = grant_idx_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    db_cnt_next = db_cnt_reg;
`ifdef STORE_AUTO_REPEAT_EN
    rpt_cnt_next = rpt_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (btn) begin
          state_next  = PRESS_DB;
          db_cnt_next = '0;
        end
      end
      PRESS_DB: begin
        if (!btn) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = ISSUE;
        end else begin
          db_cnt_next = sat_inc(db_cnt_reg);
        end
      end
      ISSUE: begin
        // Single-cycle state; the repeat count restarts on every HELD entry.
        state_next = HELD;
`ifdef STORE_AUTO_REPEAT_EN
        rpt_cnt_next = '0;
`endif
      end
      HELD: begin
        if (!btn) begin
          state_next  = RELEASE_DB;
          db_cnt_next = '0;
        end
`ifdef STORE_AUTO_REPEAT_EN
        else if (rpt_cnt_reg == RPT_LAST) begin
          state_next = ISSUE;
        end else begin
          rpt_cnt_next = sat_inc(rpt_cnt_reg);
        end
`endif
      end
      RELEASE_DB: begin
        if (btn) begin
          // Bounce during release: still held, restart the hold timing.
          state_next = HELD;
`ifdef STORE_AUTO_REPEAT_EN
          rpt_cnt_next = '0;
`endif
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = IDLE;
        end else begin
          db_cnt_next = sat_inc(db_cnt_reg);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, pointer and grant registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      db_cnt_reg    <= '0;
      ptr_reg       <= 2'd0;
      grant_idx_reg <= 2'd3;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
      // A miss leaves pointer and last grant untouched.
      if (issue_cyc && pick_valid) begin
        grant_idx_reg <= pick_idx;
        ptr_reg       <= add_mod3(pick_idx, 2'd1);
      end
    end
  end

`ifdef STORE_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_reg <= '0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_store_scheduler.sv
// -----------------------------------------------------------------------------
// tb_store_scheduler
//
// Bench for store_scheduler with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// A run-length reference model predicts store/miss/busy/grant_idx every
// cycle; a vector table of whole presses checks per-press outcomes; hand
// sequences cover auto-repeat timing and asynchronous reset while held.
// Honours STORE_AUTO_REPEAT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_store_scheduler;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic [2:0] req;
  logic [2:0] store;
  logic [1:0] grant_idx;
  logic       miss;
  logic       busy;

  store_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .req      (req),
    .store    (store),
    .grant_idx(grant_idx),
    .miss     (miss),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: button history as run lengths, not FSM states.
  bit m_pressed;   // press accepted and not yet released
  bit m_issue;     // current cycle is a grant cycle
  int m_high;      // consecutive high samples while not pressed
  int m_zero;      // consecutive low samples while pressed
  int m_hold;      // consecutive high samples since the last grant/re-hold
  int m_ptr;
  int m_gidx;
  bit h1, h2;      // two-cycle delay of btn_raw seen by the design

  int         cyc;
  int         pulses;
  int         misses;
  logic [2:0] last_store;
  int         pulse_times[$];

  typedef struct {
    int         hi;
    logic [2:0] rq;
    logic [2:0] exp_store;
    int         exp_miss;
    logic [1:0] exp_gidx;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pressed = 0; m_issue = 0; m_high = 0; m_zero = 0; m_hold = 0;
    m_ptr = 0; m_gidx = 3; h1 = 0; h2 = 0;
  endtask

  function automatic int pick(input logic [2:0] rq);
    for (int i = 0; i < 3; i++) begin
      if (rq[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
    end
    return -1;
  endfunction

  task automatic model_advance(input bit raw, input int k);
    bit b;
    b  = h2;
    h2 = h1;
    h1 = raw;
    if (m_issue) begin
      if (k >= 0) begin
        m_gidx = k;
        m_ptr  = (k + 1) % 3;
      end
      m_issue   = 0;
      m_pressed = 1;
      m_zero    = 0;
      m_hold    = 0;
    end else if (!m_pressed) begin
      if (b) begin
        if (m_high == D) begin
          m_issue = 1;
          m_high  = 0;
        end else begin
          m_high++;
        end
      end else begin
        m_high = 0;
      end
    end else begin
      if (!b) begin
        m_hold = 0;
        if (m_zero == D) begin
          m_pressed = 0;
          m_zero    = 0;
        end else begin
          m_zero++;
        end
      end else if (m_zero > 0) begin
        m_zero = 0;
        m_hold = 0;
      end else begin
`ifdef STORE_AUTO_REPEAT_EN
        if (m_hold == R - 1) m_issue = 1;
        else m_hold++;
`endif
      end
    end
  endtask

  // One clock cycle: drive at negedge, compare 1 time unit later, advance model.
  task automatic step(input bit raw, input logic [2:0] rq);
    logic [2:0] e_store;
    logic       e_miss;
    logic       e_busy;
    int         k;
    @(negedge clk);
    btn_raw = raw;
    req     = rq;
    #1;
    e_store = 3'b000;
    e_miss  = 1'b0;
    k       = -1;
    if (m_issue) begin
      k = pick(rq);
      if (k >= 0) e_store = 3'(1 << k);
      else        e_miss  = 1'b1;
    end
    e_busy = m_issue || m_pressed || (m_high > 0);
    chk("store", 32'(store), 32'(e_store));
    chk("miss", 32'(miss), 32'(e_miss));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
    if (store != 3'b000) begin
      pulses++;
      last_store = store;
      pulse_times.push_back(cyc);
    end
    if (miss) misses++;
    @(posedge clk);
    cyc++;
    model_advance(raw, k);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    pulses     = 0;
    misses     = 0;
    last_store = 3'b000;
    repeat (v.hi) step(1'b1, v.rq);
    repeat (10)   step(1'b0, v.rq);
    chk("vec_pulses", 32'(pulses), (v.exp_store != 3'b000) ? 32'd1 : 32'd0);
    chk("vec_store", 32'(last_store), 32'(v.exp_store));
    chk("vec_miss", 32'(misses), 32'(v.exp_miss));
    chk("vec_grant_idx", 32'(grant_idx), 32'(v.exp_gidx));
    chk("vec_idle", 32'(busy), 32'd0);
    $display("vec %0d: hi=%0d req=%b -> store=%b miss=%0d grant_idx=%0d", idx, v.hi, v.rq,
             last_store, misses, grant_idx);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         lvl;
    int         len;
    int         exp_pulses;
    logic [2:0] rq;
    vec_t       v;

    //             hi   req     store   miss gidx
    vecs[0]  = '{7, 3'b000, 3'b000, 1, 2'd3};  // miss before any grant
    vecs[1]  = '{3, 3'b111, 3'b000, 0, 2'd3};  // bounce, rejected
    vecs[2]  = '{4, 3'b111, 3'b000, 0, 2'd3};  // one sample short
    vecs[3]  = '{5, 3'b111, 3'b001, 0, 2'd0};  // just long enough
    vecs[4]  = '{7, 3'b111, 3'b010, 0, 2'd1};
    vecs[5]  = '{7, 3'b111, 3'b100, 0, 2'd2};
    vecs[6]  = '{7, 3'b111, 3'b001, 0, 2'd0};  // leaves ptr=1
    vecs[7]  = '{7, 3'b101, 3'b100, 0, 2'd2};  // skips bit1, wraps to bit2
    vecs[8]  = '{7, 3'b101, 3'b001, 0, 2'd0};
    vecs[9]  = '{7, 3'b110, 3'b010, 0, 2'd1};
    vecs[10] = '{7, 3'b000, 3'b000, 1, 2'd1};  // miss keeps last grant

    cyc     = 0;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    req     = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_store", 32'(store), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd3);
    $display("reset: store=%b miss=%0d busy=%0d grant_idx=%0d", store, miss, busy, grant_idx);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(i, vecs[i]);

    // Held button: one grant, plus repeats every 9 cycles when enabled.
    pulses = 0;
    pulse_times.delete();
    for (int i = 0; i < 20 && pulses == 0; i++) step(1'b1, 3'b111);
    chk("repeat_accept", 32'(pulses), 32'd1);
    repeat (30) step(1'b1, 3'b111);
    repeat (12) step(1'b0, 3'b111);
`ifdef STORE_AUTO_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    chk("repeat_pulses", 32'(pulses), 32'(exp_pulses));
    for (int i = 0; i + 1 < pulse_times.size(); i++) begin
      chk("repeat_spacing", 32'(pulse_times[i + 1] - pulse_times[i]), 32'd9);
    end
    $display("hold: %0d store pulses while held", pulses);

    // Random button runs with req changing every cycle.
    for (int r = 0; r < 250; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        rq = 3'($urandom_range(0, 7));
        step(lvl, rq);
      end
    end
    repeat (12) step(1'b0, 3'b000);
    $display("random: %0d cycles against reference model", cyc);

    // Asynchronous reset while HELD.
    repeat (8) step(1'b1, 3'b111);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_store", 32'(store), 32'd0);
    chk("async_miss", 32'(miss), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_grant_idx", 32'(grant_idx), 32'd3);
    $display("async reset in held: store=%b miss=%0d busy=%0d grant_idx=%0d",
             store, miss, busy, grant_idx);
    model_reset();
    btn_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{7, 3'b111, 3'b001, 0, 2'd0};
    apply_vec(99, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
